// File: rtl/clint_wb_multi.sv
// rtl/clint_wb_multi.sv - multi-hart machine timer / software interrupt controller on a Wishbone classic slave
//
// Ports:
//   wb_clk_i            clock, all logic on the rising edge
//   wb_rst_i            synchronous active-high reset
//   wb_cyc_i, wb_stb_i  bus cycle / strobe
//   wb_we_i             1 = write, 0 = read
//   wb_adr_i[31:0]      byte address, bits [1:0] ignored
//   wb_sel_i[3:0]       byte lane enables for writes
//   wb_dat_i[31:0]      write data
//   wb_dat_o[31:0]      read data, zero whenever wb_ack_o is low
//   wb_ack_o            single-cycle registered acknowledge
//   mtip_o[NUM_HARTS]   machine timer interrupt pending per hart
//   msip_o[NUM_HARTS]   machine software interrupt pending per hart

module clint_wb_multi #(
    parameter int unsigned NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0C00,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [NUM_HARTS-1:0] msip_o
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [63:0] mtime;
    logic [31:0] mtime_hi_shadow;
    logic [15:0] tick_cnt;
    logic [63:0] mtimecmp [NUM_HARTS];
    logic [31:0] rdata;
    logic [31:0] rdata_q;

    // Word offset into the 512-byte window; the window is naturally aligned,
    // so everything above the 7-bit word index must be zero to be a hit.
    logic [29:0] woff;
    logic [6:0]  word;
    logic        in_win;
    logic        req;
    logic        wr;
    logic        rd;
    logic        is_msip;
    logic        is_cmp;
    logic        is_mtime_lo;
    logic        is_mtime_hi;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        tick;
    logic        unused_adr;

    assign unused_adr  = &{1'b0, wb_adr_i[1:0]};

    assign woff        = wb_adr_i[31:2] - BASE_ADDR[31:2];
    assign in_win      = (woff[29:7] == '0);
    assign word        = woff[6:0];

    assign req         = wb_cyc_i & wb_stb_i & in_win & ~wb_ack_o;
    assign wr          = req & wb_we_i;
    assign rd          = req & ~wb_we_i;

    assign is_msip     = ~word[6];
    assign is_cmp      = word[6] & (word[5:1] != 5'h1F);
    assign is_mtime_lo = (word == 7'h7E);
    assign is_mtime_hi = (word == 7'h7F);

    // An mtime write with no byte lanes enabled is a pure no-op, including
    // leaving the prescaler alone.
    assign wr_mtime_lo = wr & is_mtime_lo & (|wb_sel_i);
    assign wr_mtime_hi = wr & is_mtime_hi & (|wb_sel_i);

    assign tick        = (tick_cnt == TICK_LAST);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Read mux; unmapped offsets (including harts beyond NUM_HARTS) fall through to 0.
    always_comb begin
        rdata = '0;
        if (is_mtime_lo) begin
            rdata = mtime[31:0];
        end else if (is_mtime_hi) begin
            rdata = mtime_hi_shadow;
        end
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
            if (is_msip && (word[5:0] == 6'(h))) begin
                rdata = {31'd0, msip_o[h]};
            end
            if (is_cmp && (word[5:1] == 5'(h))) begin
                rdata = word[0] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
            end
        end
    end

    // Bus handshake: ack follows req by one cycle, and the ack itself masks req,
    // so a held strobe produces an ack every other cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                rdata_q <= wb_we_i ? 32'd0 : rdata;
            end
        end
    end

    assign wb_dat_o = wb_ack_o ? rdata_q : 32'd0;

    // Per-hart MSIP and MTIMECMP registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            msip_o <= '0;
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                mtimecmp[h] <= '1;
            end
        end else begin
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                if (wr && is_msip && (word[5:0] == 6'(h)) && wb_sel_i[0]) begin
                    msip_o[h] <= wb_dat_i[0];
                end
                if (wr && is_cmp && (word[5:1] == 5'(h))) begin
                    if (word[0]) begin
                        mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wb_dat_i, wb_sel_i);
                    end else begin
                        mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], wb_dat_i, wb_sel_i);
                    end
                end
            end
        end
    end

    // mtime and prescaler. A bus write to either half takes priority over the
    // tick: the other half holds, nothing increments, and the prescaler restarts.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mtime    <= '0;
            tick_cnt <= '0;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            mtime[31:0]  <= wr_mtime_lo ? merge_bytes(mtime[31:0], wb_dat_i, wb_sel_i) : mtime[31:0];
            mtime[63:32] <= wr_mtime_hi ? merge_bytes(mtime[63:32], wb_dat_i, wb_sel_i) : mtime[63:32];
            tick_cnt     <= '0;
        end else begin
            if (tick) begin
                mtime    <= mtime + 64'd1;
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    // Reading the low word snapshots the high word so a low-then-high read
    // pair is coherent across a carry out of bit 31.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mtime_hi_shadow <= '0;
        end else if (rd && is_mtime_lo) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mtip_o <= '0;
        end else begin
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                mtip_o[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

endmodule

// File: tb/tb_clint_wb_multi.sv
// tb/tb_clint_wb_multi.sv - directed self-checking bench for clint_wb_multi

module tb_clint_wb_multi;

    localparam logic [31:0] BASE = 32'h2000_0C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic [31:0] dat_o;
    logic [31:0] dat4_o;
    logic        ack;
    logic        ack4;
    logic [1:0]  mtip;
    logic [1:0]  msip;
    logic [0:0]  mtip4;
    logic [0:0]  msip4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] r;
    logic [31:0] r4;
    logic        ok;
    logic [5:0]  ack_pat;
    logic [31:0] exp4 [5] = '{32'd10, 32'd10, 32'd11, 32'd11, 32'd12};

    always #5 clk = ~clk;

    clint_wb_multi #(.NUM_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .mtip_o(mtip), .msip_o(msip)
    );

    clint_wb_multi #(.NUM_HARTS(1), .BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat4_o), .wb_ack_o(ack4),
        .mtip_o(mtip4), .msip_o(msip4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus access, bounded to four cycles waiting for ack.
    task automatic bus(input logic w, input logic [31:0] off, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd_d,
                       output logic [31:0] rd_d4, output logic got_ack);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + off; sel = s; wdat = d;
        got_ack = 1'b0;
        rd_d = '0;
        rd_d4 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                got_ack = 1'b1;
                rd_d  = dat_o;
                rd_d4 = dat4_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] x;
        logic [31:0] x4;
        logic        a;
        bus(1'b1, off, s, d, x, x4, a);
        check({tag, "_ack"}, 64'(a), 64'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] off, output logic [31:0] d, output logic [31:0] d4);
        logic a;
        bus(1'b0, off, 4'hF, 32'd0, d, d4, a);
        check({tag, "_ack"}, 64'(a), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        check("rst_ack4", 64'({ack4, mtip4, msip4}), 64'd0);
        rst = 1'b0;

        // Idle 10 clocks, then read mtime and MTIMECMP0
        repeat (10) @(posedge clk);
        rd("mtime_lo", 32'h1F8, r, r4);
        check("idle_mtime_lo", 64'(r), 64'd10);
        check("idle_mtime4_lo", 64'(r4), 64'd2);
        rd("mtime_hi", 32'h1FC, r, r4);
        check("idle_mtime_hi", 64'(r), 64'd0);
        check("idle_mtip", 64'(mtip), 64'd0);
        rd("cmp0_lo", 32'h100, r, r4);
        check("cmp0_lo_rst", 64'(r), 64'hFFFF_FFFF);
        rd("cmp0_hi", 32'h104, r, r4);
        check("cmp0_hi_rst", 64'(r), 64'hFFFF_FFFF);

        // mtime = 0, then prescaled counting
        wr("mt_hi0", 32'h1FC, 4'hF, 32'd0);
        wr("mt_lo0", 32'h1F8, 4'hF, 32'd0);
        repeat (40) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            rd("tick", 32'h1F8, r, r4);
            check("tick4_lo", 64'(r4), 64'(exp4[i]));
            check("tick1_lo", 64'(r), 64'(40 + 2 * i));
        end

        // mtip for hart 1 at mtime = 100
        wr("cmp1_lo", 32'h108, 4'hF, 32'h0000_0064);
        wr("cmp1_hi", 32'h10C, 4'hF, 32'h0000_0000);
        check("mtip_before", 64'(mtip), 64'd0);
        wr("mt_hi", 32'h1FC, 4'hF, 32'd0);
        wr("mt_lo90", 32'h1F8, 4'hF, 32'd90);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mtip_at_100", 64'(mtip), 64'b00);
        @(negedge clk);
        check("mtip_after_100", 64'(mtip), 64'b10);
        wr("cmp1_raise", 32'h108, 4'hF, 32'hFFFF_FFFF);
        check("mtip_clr_lat", 64'(mtip), 64'b10);
        @(negedge clk);
        check("mtip_clr", 64'(mtip), 64'b00);

        // Tear-free read across the 32-bit carry
        wr("mt_hi1", 32'h1FC, 4'hF, 32'h0000_0001);
        wr("mt_lofe", 32'h1F8, 4'hF, 32'hFFFF_FFFE);
        rd("tf_lo1", 32'h1F8, r, r4);
        check("tf_lo1", 64'(r), 64'hFFFF_FFFF);
        rd("tf_hi1", 32'h1FC, r, r4);
        check("tf_hi1", 64'(r), 64'h1);
        rd("tf_lo2", 32'h1F8, r, r4);
        check("tf_lo2", 64'(r), 64'h3);
        rd("tf_hi2", 32'h1FC, r, r4);
        check("tf_hi2", 64'(r), 64'h2);

        // Software interrupts and unmapped / out-of-window accesses
        wr("msip1_set", 32'h004, 4'b0001, 32'h1);
        check("msip1_set", 64'(msip), 64'b10);
        wr("msip1_nosel", 32'h004, 4'b0000, 32'h0);
        check("msip1_nosel", 64'(msip), 64'b10);
        rd("msip1_rd", 32'h004, r, r4);
        check("msip1_rd", 64'(r), 64'h1);
        wr("msip0_all", 32'h000, 4'hF, 32'hFFFF_FFFF);
        check("msip0_all", 64'(msip), 64'b11);
        rd("msip0_rd", 32'h000, r, r4);
        check("msip0_rd", 64'(r), 64'h1);
        rd("hart5", 32'h014, r, r4);
        check("hart5_rd", 64'(r), 64'h0);
        bus(1'b0, 32'h200, 4'hF, 32'd0, r, r4, ok);
        check("above_win_noack", 64'(ok), 64'd0);
        bus(1'b0, 32'hFFFF_FFFC, 4'hF, 32'd0, r, r4, ok);
        check("below_win_noack", 64'(ok), 64'd0);

        // Byte-lane write into MTIMECMP0 high
        wr("cmp0_b1", 32'h104, 4'b0010, 32'h0000_AB00);
        rd("cmp0_b1", 32'h104, r, r4);
        check("cmp0_byte1", 64'(r), 64'hFFFF_ABFF);

        // Held strobe: one ack every other cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h004; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack_pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_stb_acks", 64'(ack_pat), 64'b010101);

        // Reset coincident with a write request
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; sel = 4'hF; wdat = 32'h1234_5678;
        rst = 1'b1;
        @(negedge clk);
        check("rst_wr_ack", 64'(ack), 64'd0);
        check("rst_wr_msip", 64'(msip), 64'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        rd("rst_cmp0", 32'h100, r, r4);
        check("rst_cmp0_lo", 64'(r), 64'hFFFF_FFFF);
        rd("rst_cmp0h", 32'h104, r, r4);
        check("rst_cmp0_hi", 64'(r), 64'hFFFF_FFFF);
        check("rst_wr_mtip", 64'(mtip), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
